uart_fifo_unit: RTL and testbench

UART_FIFO_UNIT -- requirements
Module: uart_fifo_unit

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_sync_fifo.sv | 50 +++++
 rtl/uart_fifo_unit.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART FIFO unit: register offsets,
// CON bit positions, TX/RX state encodings and a parity helper.
package uart_pkg;

  localparam logic [31:0] OFF_TXD = 32'h0;
  localparam logic [31:0] OFF_RXD = 32'h4;
  localparam logic [31:0] OFF_CON = 32'h8;
  localparam logic [31:0] OFF_DIV = 32'hC;

  localparam int CON_TXIE   = 0;
  localparam int CON_RXIE   = 1;
  localparam int CON_PAREN  = 2;
  localparam int CON_PARODD = 3;
  localparam int CON_TXIDLE = 4;
  localparam int CON_RXNE   = 5;
  localparam int CON_TXFULL = 6;
  localparam int CON_OVR    = 7;
  localparam int CON_FERR   = 8;
  localparam int CON_TXOVF  = 9;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Parity bit that makes the total count of ones even (or odd).
  function automatic logic par_bit(
    input logic [7:0] d,
    input logic       odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with show-ahead head output.
// Ports: clk, rst_n, push/wdata in, pop in, full/empty/head out.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  // Extra pointer bit tells full from empty when indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_unit.sv
// UART with TX/RX FIFOs, baud tick generator and bus registers.
// Ports: CLK, Reset_n, rd/wr/addr/wdata/rdata bus, tx_out, rx_in, irq.
module uart_fifo_unit
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h40000018,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd15,
  parameter int          OVERSAMPLE = 16
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx_out,
  input  logic        rx_in,
  output logic        irq
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);

  logic sel_txd, sel_rxd, sel_con, sel_div;
  logic wr_txd, wr_con, wr_div, rd_rxd;

  assign sel_txd = (addr == BASE_ADDR + OFF_TXD);
  assign sel_rxd = (addr == BASE_ADDR + OFF_RXD);
  assign sel_con = (addr == BASE_ADDR + OFF_CON);
  assign sel_div = (addr == BASE_ADDR + OFF_DIV);
  assign wr_txd  = wr & sel_txd;
  assign wr_con  = wr & sel_con;
  assign wr_div  = wr & sel_div;
  assign rd_rxd  = rd & sel_rxd;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:16];

  logic [3:0]  ctrl_q, ctrl_d;
  logic [2:0]  sticky_q, sticky_d;
  logic [15:0] div_q, div_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic        irq_q, irq_d;
  logic        tick;

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;

  tx_state_e      tx_state_q, tx_state_d;
  logic [OSW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]     tx_idx_q, tx_idx_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           tx_out_q, tx_out_d;
  logic           tx_end, tx_idle;

  rx_state_e      rx_state_q, rx_state_d;
  logic [OSW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]     rx_idx_q, rx_idx_d;
  logic [7:0]     rx_byte_q, rx_byte_d;
  logic           rx_par_q, rx_par_d;
  logic [1:0]     sync_q;
  logic           rx_prev_q;
  logic           rx_s, rx_end, rx_half, par_ok;
  logic           rx_good, rx_bad;

  logic [31:0] con_val;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (CLK),
    .rst_n (Reset_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (wdata[7:0]),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (tx_head)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (CLK),
    .rst_n (Reset_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_byte_q),
    .full  (rx_full),
    .empty (rx_empty),
    .head  (rx_head)
  );

  assign tick = (tick_cnt_q == div_q);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 16'd1;
    if (wr_div) tick_cnt_d = '0;
  end

  // ---------------- TX engine ----------------
  assign tx_end  = tick && (tx_cnt_q == OS_LAST);
  assign tx_idle = (tx_state_q == TX_IDLE) && tx_empty;
  // Engine pop frees a slot in the same cycle as a bus write.
  assign tx_push = wr_txd && (!tx_full || tx_pop);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_byte_d  = tx_byte_q;
    tx_out_d   = tx_out_q;
    tx_pop     = 1'b0;
    if (tick && tx_state_q != TX_IDLE)
      tx_cnt_d = tx_end ? '0 : tx_cnt_q + 1'b1;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_byte_d  = tx_head;
          tx_cnt_d   = '0;
          tx_out_d   = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_end) begin
          tx_idx_d   = '0;
          tx_out_d   = tx_byte_q[0];
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_end) begin
          if (tx_idx_q == 3'd7) begin
            if (ctrl_q[CON_PAREN]) begin
              tx_out_d   = par_bit(tx_byte_q,
                                   ctrl_q[CON_PARODD]);
              tx_state_d = TX_PARITY;
            end else begin
              tx_out_d   = 1'b1;
              tx_state_d = TX_STOP;
            end
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            tx_out_d = tx_byte_q[tx_idx_q + 3'd1];
          end
        end
      end
      TX_PARITY: begin
        if (tx_end) begin
          tx_out_d   = 1'b1;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_end) begin
          // Chain straight into the next frame with no idle gap.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_byte_d  = tx_head;
            tx_out_d   = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_out_d   = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: begin
        tx_out_d   = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // ---------------- RX engine ----------------
  assign rx_s    = sync_q[1];
  assign rx_end  = tick && (rx_cnt_q == OS_LAST);
  assign rx_half = tick && (rx_cnt_q == OS_HALF);
  assign par_ok  = ((^rx_byte_q) ^ rx_par_q) == ctrl_q[CON_PARODD];
  assign rx_pop  = rd_rxd && !rx_empty;
  assign rx_push = rx_good && (!rx_full || rx_pop);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_byte_d  = rx_byte_q;
    rx_par_d   = rx_par_q;
    rx_good    = 1'b0;
    rx_bad     = 1'b0;
    if (tick && rx_state_q != RX_IDLE)
      rx_cnt_d = rx_end ? '0 : rx_cnt_q + 1'b1;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // Mid start bit: high here means it was a glitch.
        if (rx_half) begin
          if (rx_s) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_cnt_d   = '0;
            rx_idx_d   = '0;
            rx_state_d = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (rx_end) begin
          rx_byte_d = {rx_s, rx_byte_q[7:1]};
          rx_idx_d  = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7)
            rx_state_d = ctrl_q[CON_PAREN] ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (rx_end) begin
          rx_par_d   = rx_s;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_end) begin
          rx_state_d = RX_IDLE;
          if (rx_s && (!ctrl_q[CON_PAREN] || par_ok))
            rx_good = 1'b1;
          else
            rx_bad = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- registers ----------------
  assign con_val = {22'b0, sticky_q, tx_full, !rx_empty,
                    tx_idle, ctrl_q};

  always_comb begin
    logic [2:0] set_v;
    logic [2:0] clr_v;
    set_v = {rx_bad, rx_good && rx_full && !rx_pop, 1'b0};
    set_v = {wr_txd && tx_full && !tx_pop,
             rx_bad,
             rx_good && rx_full && !rx_pop};
    clr_v = wr_con ? wdata[9:7] : 3'b0;
    // Set wins over a same-cycle clear.
    sticky_d = (sticky_q & ~clr_v) | set_v;
    ctrl_d   = wr_con ? wdata[3:0] : ctrl_q;
    div_d    = wr_div ? wdata[15:0] : div_q;
    irq_d    = (ctrl_q[CON_TXIE] & con_val[CON_TXIDLE]) |
               (ctrl_q[CON_RXIE] & con_val[CON_RXNE]) |
               (|sticky_q);
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      unique case (1'b1)
        sel_rxd: rdata = rx_empty ? '0 : {24'b0, rx_head};
        sel_con: rdata = con_val;
        sel_div: rdata = {16'b0, div_q};
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      ctrl_q     <= '0;
      sticky_q   <= '0;
      div_q      <= DIV_RESET;
      tick_cnt_q <= '0;
      irq_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_byte_q  <= '0;
      tx_out_q   <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_byte_q  <= '0;
      rx_par_q   <= 1'b0;
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
    end else begin
      ctrl_q     <= ctrl_d;
      sticky_q   <= sticky_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      irq_q      <= irq_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_out_q   <= tx_out_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_byte_q  <= rx_byte_d;
      rx_par_q   <= rx_par_d;
      sync_q     <= {sync_q[0], rx_in};
      rx_prev_q  <= rx_s;
    end
  end

  assign tx_out = tx_out_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_uart_fifo_unit.sv
// Directed self-checking bench for uart_fifo_unit.
// Covers reset, TX framing, loopback, overflow, parity, glitch, reset.
module tb_uart_fifo_unit;

  localparam logic [31:0] A_TXD = 32'h40000018;
  localparam logic [31:0] A_RXD = 32'h4000001C;
  localparam logic [31:0] A_CON = 32'h40000020;
  localparam logic [31:0] A_DIV = 32'h40000024;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        tx_out, rx_in, irq;
  logic        loop, rx_drv;

  int n_checks = 0;
  int n_fail   = 0;

  assign rx_in = loop ? tx_out : rx_drv;

  always #5 CLK = ~CLK;

  uart_fifo_unit dut (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .tx_out  (tx_out),
    .rx_in   (rx_in),
    .irq     (irq)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1;
    addr = a;
    wdata = d;
    wait_clk(1);
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1;
    addr = a;
    #1;
    d = rdata;
    wait_clk(1);
    rd = 1'b0;
  endtask

  // Side-effect free look at a register between clock edges.
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1;
    addr = a;
    #1;
    d = rdata;
    rd = 1'b0;
  endtask

  task automatic send_frame(
    input logic [7:0] b,
    input logic       pen,
    input logic       pb
  );
    rx_drv = 1'b0;
    wait_clk(16);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      wait_clk(16);
    end
    if (pen) begin
      rx_drv = pb;
      wait_clk(16);
    end
    rx_drv = 1'b1;
    wait_clk(16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  pat;
    Reset_n = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
    addr = '0;
    wdata = '0;
    loop = 1'b0;
    rx_drv = 1'b1;
    wait_clk(3);
    Reset_n = 1'b1;
    wait_clk(1);

    check("rst_tx", {31'b0, tx_out}, 32'h1);
    check("rst_irq", {31'b0, irq}, 32'h0);
    peek(A_CON, v);
    check("rst_con", v, 32'h10);
    peek(A_DIV, v);
    check("rst_div", v, 32'd15);
    peek(A_RXD, v);
    check("rst_rxd", v, 32'h0);
    peek(A_TXD, v);
    check("txd_rd0", v, 32'h0);

    // TX framing at one tick per clock
    bus_wr(A_DIV, 32'h0);
    bus_wr(A_TXD, 32'h55);
    check("tx_pre", {31'b0, tx_out}, 32'h1);
    wait_clk(1);
    check("tx_start", {31'b0, tx_out}, 32'h0);
    wait_clk(15);
    check("start_end", {31'b0, tx_out}, 32'h0);
    pat = 8'h55;
    wait_clk(1);
    check("tx_bit0", {31'b0, tx_out}, {31'b0, pat[0]});
    for (int i = 1; i < 8; i++) begin
      wait_clk(16);
      check($sformatf("tx_bit%0d", i), {31'b0, tx_out},
            {31'b0, pat[i]});
    end
    wait_clk(16);
    check("tx_stop", {31'b0, tx_out}, 32'h1);
    peek(A_CON, v);
    check("busy_stop", {31'b0, v[4]}, 32'h0);
    wait_clk(15);
    peek(A_CON, v);
    check("busy_end", {31'b0, v[4]}, 32'h0);
    wait_clk(1);
    peek(A_CON, v);
    check("tx_idle", {31'b0, v[4]}, 32'h1);

    // Loopback at DIV=2
    loop = 1'b1;
    bus_wr(A_CON, 32'h2);
    bus_wr(A_DIV, 32'h2);
    bus_wr(A_TXD, 32'hA5);
    bus_wr(A_TXD, 32'h3C);
    wait_clk(2);
    check("lb_irq0", {31'b0, irq}, 32'h0);
    wait_clk(1200);
    check("lb_irq1", {31'b0, irq}, 32'h1);
    bus_rd(A_RXD, v);
    check("lb_rx0", v, 32'hA5);
    check("lb_irq2", {31'b0, irq}, 32'h1);
    bus_rd(A_RXD, v);
    check("lb_rx1", v, 32'h3C);
    wait_clk(1);
    check("lb_irq3", {31'b0, irq}, 32'h0);
    bus_rd(A_RXD, v);
    check("lb_rx2", v, 32'h0);
    loop = 1'b0;

    // Even parity, frame 0x01 needs parity bit 1
    bus_wr(A_DIV, 32'h0);
    bus_wr(A_CON, 32'h4);
    send_frame(8'h01, 1'b1, 1'b0);
    wait_clk(4);
    peek(A_CON, v);
    check("par_bad", v, 32'h114);
    check("par_irq", {31'b0, irq}, 32'h1);
    bus_wr(A_CON, 32'h104);
    peek(A_CON, v);
    check("ferr_w1c", v, 32'h14);
    send_frame(8'h01, 1'b1, 1'b1);
    wait_clk(4);
    bus_rd(A_RXD, v);
    check("par_ok", v, 32'h01);
    peek(A_CON, v);
    check("par_con", v, 32'h14);

    // Short low glitch must be rejected
    bus_wr(A_CON, 32'h0);
    rx_drv = 1'b0;
    wait_clk(4);
    rx_drv = 1'b1;
    wait_clk(40);
    peek(A_CON, v);
    check("glitch_con", v, 32'h10);
    peek(A_RXD, v);
    check("glitch_rxd", v, 32'h0);

    // TX FIFO overflow at slow baud
    bus_wr(A_DIV, 32'd100);
    for (int i = 0; i < 10; i++)
      bus_wr(A_TXD, 32'h10 + i);
    peek(A_CON, v);
    check("ovf_con", v, 32'h240);
    wait_clk(1);
    check("ovf_irq", {31'b0, irq}, 32'h1);
    check("ovf_txlo", {31'b0, tx_out}, 32'h0);
    bus_wr(A_CON, 32'h200);
    peek(A_CON, v);
    check("ovf_w1c", v, 32'h40);
    wait_clk(1);
    check("ovf_irq0", {31'b0, irq}, 32'h0);

    // Reset in the middle of a frame
    Reset_n = 1'b0;
    #1;
    check("mid_rst_tx", {31'b0, tx_out}, 32'h1);
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    wait_clk(2);
    Reset_n = 1'b1;
    wait_clk(1);
    peek(A_CON, v);
    check("post_con", v, 32'h10);
    peek(A_DIV, v);
    check("post_div", v, 32'd15);
    wait_clk(20);
    check("post_tx", {31'b0, tx_out}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
